gf16_inverse_seq: RTL and testbench

Sequential GF(2^4) multiplicative inverter for the S-box datapath. It computes a^-1 = a^14 arithmetically, using square-and-multiply over the field polynomial x^4+x+1, instead of by table lookup. The result is bit-identical to the team's combinational inverse table for all 16 inputs, which makes this block the arithmetic counterpart used for cross-checking and for area-constrained S-box builds. It accepts one element through a valid/ready input port and returns its inverse through a valid/ready output port.

---
 rtl/gf16_inverse_seq.sv | 86 ++++++++
 tb/tb_gf16_inverse_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gf16_inverse_seq.sv
// rtl/gf16_inverse_seq.sv - sequential GF(2^4) inverter computing a^14 by square-and-multiply
module gf16_inverse_seq #(
  parameter logic [3:0] POLY = 4'b0011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, C1, C2, C3, OUT} state_t;

  state_t     state, state_next;
  logic [3:0] a_q, sq, acc;
  logic [3:0] sq_a, sq_sq, acc_mul;

  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) p = p ^ t;
      t = t[3] ? ({t[2:0], 1'b0} ^ POLY) : {t[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_sq(input logic [3:0] x);
    return gf_mul(x, x);
  endfunction

  assign sq_a    = gf_sq(a_q);
  assign sq_sq   = gf_sq(sq);
  assign acc_mul = gf_mul(acc, sq_sq);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = C1;
      C1:      state_next = C2;
      C2:      state_next = C3;
      C3:      state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sq walks a^2, a^4, a^8 while acc folds in each power: a^2 * a^4 * a^8 = a^14
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= 4'h0;
      sq  <= 4'h0;
      acc <= 4'h0;
    end else begin
      case (state)
        IDLE: if (in_valid) a_q <= in_data;
        C1: begin
          sq  <= sq_a;
          acc <= sq_a;
        end
        C2, C3: begin
          sq  <= sq_sq;
          acc <= acc_mul;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state == C1) || (state == C2) || (state == C3);
  assign out_data  = out_valid ? acc : 4'h0;

endmodule

// File: tb/tb_gf16_inverse_seq.sv
// tb/tb_gf16_inverse_seq.sv - self-checking bench for gf16_inverse_seq against a field-arithmetic model
module tb_gf16_inverse_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  logic [3:0] tbl [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                           4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

  gf16_inverse_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Polynomial product then long-division reduction by x^4+x+1 (0x13)
  function automatic int ref_mul(input int x, input int y);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if ((y >> i) & 1) p = p ^ (x << i);
    for (int b = 7; b >= 4; b--) if ((p >> b) & 1) p = p ^ (32'h13 << (b - 4));
    return p;
  endfunction

  function automatic int ref_inv(input int a);
    if (a == 0) return 0;
    for (int b = 1; b < 16; b++) if (ref_mul(a, b) == 1) return b;
    return -1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_one(input logic [3:0] a, input int hold, input logic nv,
                         input logic [3:0] nd, output logic [3:0] got);
    int lat;
    int exp;
    exp = ref_inv(int'(a));
    in_valid  = 1'b1;
    in_data   = a;
    out_ready = 1'b0;
    chk("in_ready_before_accept", int'(in_ready), 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = nv;
    in_data  = nd;
    while (!out_valid && lat < 10) begin
      chk("busy_while_computing", int'(busy), 1);
      chk("in_ready_while_computing", int'(in_ready), 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency_edges", lat, 4);
    for (int h = 0; h < hold; h++) begin
      chk("held_out_valid", int'(out_valid), 1);
      chk("held_out_data", int'(out_data), exp);
      chk("held_in_ready", int'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
    end
    got = out_data;
    chk("out_data_vs_model", int'(out_data), exp);
    chk("busy_in_out", int'(busy), 0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    if (out_valid) n_xfer++;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_transfer", int'(in_ready), 1);
    chk("out_valid_after_transfer", int'(out_valid), 0);
  endtask

  initial begin
    logic [3:0] got;
    int xfer0;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_data", int'(out_data), 0);

    run_one(4'h2, 0, 1'b0, 4'h0, got);
    chk("inv_2", int'(got), 9);

    xfer0 = n_xfer;
    for (int a = 0; a < 16; a++) begin
      run_one(4'(a), 0, 1'b0, 4'(a), got);
      chk("sweep_table", int'(got), int'(tbl[a]));
      if (a != 0) chk("sweep_product", ref_mul(a, int'(got)), 1);
    end
    chk("sweep_transfers", n_xfer - xfer0, 16);

    run_one(4'h8, 10, 1'b1, 4'h3, got);
    chk("backpressure_8", int'(got), 15);
    run_one(4'h3, 0, 1'b0, 4'h0, got);
    chk("after_backpressure_3", int'(got), 14);

    in_valid = 1'b1; in_data = 4'hA;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_c2_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_c2_in_ready", int'(in_ready), 1);
    chk("rst_c2_out_valid", int'(out_valid), 0);
    chk("rst_c2_out_data", int'(out_data), 0);
    chk("rst_c2_busy", int'(busy), 0);
    xfer0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) xfer0++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_c2_no_transfer", xfer0, 0);

    rst = 1'b1; in_valid = 1'b1; in_data = 4'h5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_beats_in_valid", int'(busy), 0);

    run_one(4'h4, 0, 1'b0, 4'h7, got);
    chk("in_data_changed_4", int'(got), 13);
    run_one(4'h0, 0, 1'b0, 4'h0, got);
    chk("zero_maps_zero", int'(got), 0);
    run_one(4'h1, 0, 1'b0, 4'h0, got);
    chk("one_maps_one", int'(got), 1);

    for (int r = 0; r < 24; r++) begin
      run_one(4'($urandom_range(15)), int'($urandom_range(3)), 1'($urandom),
              4'($urandom), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
